mac_rx_pkt_fifo: RTL and testbench

- Store-and-forward packet FIFO directly downstream of the MAC RX stage.
- Accepts the MAC's AXI-Stream output, which has no backpressure. tuser=1 means the beat is good; tuser=0 means the frame is errored, mid-frame or on the tlast beat.
- Buffers each frame and releases only frames that end cleanly on the output AXI-Stream, which has tready.
- Errored and overflowing frames are discarded by rolling back the write pointer; per-class frame counters are kept.

---
 rtl/mac_params.sv | 17 +
 rtl/mac_rx_pkt_fifo_if.sv | 15 +
 rtl/cmn_sdp_ram.sv | 27 ++
 rtl/mac_rx_pkt_fifo.sv | 159 +++++++++++++++
 tb/tb_mac_rx_pkt_fifo.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_params.sv
// rtl/mac_params.sv - shared MAC datapath parameters and rx-fifo types
package mac_params;

    localparam int N_SYMBOLS   = 4;
    localparam int W_SYMBOL    = 8;
    localparam int W_DATA      = N_SYMBOLS * W_SYMBOL;
    // Stored beat: {tlast, tkeep, tdata}
    localparam int W_RXF_ENTRY = 1 + N_SYMBOLS + W_DATA;

    // One-hot write-side states of the rx packet fifo
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_FRAME = 3'b010,
        ST_DROP  = 3'b100
    } state_t;

endpackage

// File: rtl/mac_rx_pkt_fifo_if.sv
// rtl/mac_rx_pkt_fifo_if.sv - AXI-Stream style beat bundle for the rx packet fifo
interface mac_rx_pkt_fifo_if;
    import mac_params::*;

    logic                 tvalid;
    logic                 tready;
    logic [N_SYMBOLS-1:0] tkeep;
    logic [W_DATA-1:0]    tdata;
    logic                 tlast;
    logic                 tuser;

    modport master (output tvalid, tkeep, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tkeep, tdata, tlast, tuser, output tready);

endinterface

// File: rtl/cmn_sdp_ram.sv
// rtl/cmn_sdp_ram.sv - simple dual-port RAM, one write port, registered read port
module cmn_sdp_ram #(
    parameter int W_ADDR = 9,
    parameter int W_DATA = 8
) (
    input  logic              i_clk,
    input  logic              wr_en,
    input  logic [W_ADDR-1:0] wr_addr,
    input  logic [W_DATA-1:0] wr_data,
    input  logic              rd_en,
    input  logic [W_ADDR-1:0] rd_addr,
    output logic [W_DATA-1:0] rd_data
);

    logic [W_DATA-1:0] mem [0:(1<<W_ADDR)-1];

    // Write port; contents are deliberately left unreset
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read port with one cycle of latency, holds last word when idle
    always_ff @(posedge i_clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mac_rx_pkt_fifo.sv
// rtl/mac_rx_pkt_fifo.sv - store-and-forward rx packet fifo with frame rollback
module mac_rx_pkt_fifo
    import mac_params::*;
#(
    parameter int W_ADDR = 9,
    parameter int W_CNT  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clk_en,
    mac_rx_pkt_fifo_if.slave   s_axis,
    mac_rx_pkt_fifo_if.master  m_axis,
    output logic [W_CNT-1:0]   o_frames_ok,
    output logic [W_CNT-1:0]   o_frames_err,
    output logic [W_CNT-1:0]   o_frames_ovf
);

    state_t                   state;
    logic [W_ADDR-1:0]        wr_ptr;
    logic [W_ADDR-1:0]        wr_ptr_nxt;
    logic [W_ADDR-1:0]        commit_ptr;
    logic [W_ADDR-1:0]        rd_ptr;
    logic                     in_beat;
    logic                     full;
    logic                     wr_en;
    logic [W_RXF_ENTRY-1:0]   wr_data;

    logic                     rd_en;
    logic                     ram_vld;
    logic [W_RXF_ENTRY-1:0]   ram_data;
    logic                     out_vld;
    logic [W_RXF_ENTRY-1:0]   out_q;
    logic                     skid_vld;
    logic [W_RXF_ENTRY-1:0]   skid_q;
    logic                     pop;
    logic [1:0]               held;

    // The MAC cannot be stalled, and the output side never tags errors
    assign s_axis.tready = 1'b1;
    assign m_axis.tuser  = 1'b1;

    // Write qualification; full uses the rd_ptr from the start of the cycle
    always_comb begin
        in_beat    = s_axis.tvalid & i_clk_en;
        wr_ptr_nxt = wr_ptr + 1'b1;
        full       = (wr_ptr_nxt == rd_ptr);
        wr_en      = in_beat && (state != ST_DROP) && s_axis.tuser && !full;
        wr_data    = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end

    // Write-side FSM: append beats, commit on clean tlast, roll back otherwise
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            o_frames_ok  <= '0;
            o_frames_err <= '0;
            o_frames_ovf <= '0;
        end else if (in_beat) begin
            unique case (state)
                ST_IDLE, ST_FRAME: begin
                    if (!s_axis.tuser) begin
                        wr_ptr       <= commit_ptr;
                        o_frames_err <= o_frames_err + 1'b1;
                        state        <= ST_IDLE;
                    end else if (full) begin
                        wr_ptr <= commit_ptr;
                        // A full hit on the final beat has nothing left to skip
                        if (s_axis.tlast) begin
                            o_frames_ovf <= o_frames_ovf + 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            state <= ST_DROP;
                        end
                    end else begin
                        wr_ptr <= wr_ptr_nxt;
                        if (s_axis.tlast) begin
                            commit_ptr  <= wr_ptr_nxt;
                            o_frames_ok <= o_frames_ok + 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_FRAME;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis.tlast || !s_axis.tuser) begin
                        o_frames_ovf <= o_frames_ovf + 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cmn_sdp_ram #(
        .W_ADDR (W_ADDR),
        .W_DATA (W_RXF_ENTRY)
    ) u_ram (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_data)
    );

    // Fetch only committed beats, and only if out+skid can absorb the read
    always_comb begin
        pop   = out_vld & m_axis.tready;
        held  = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, ram_vld} - {1'b0, pop};
        rd_en = (rd_ptr != commit_ptr) && (held < 2'd2);
    end

    // Read pointer and RAM output valid tracking
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr  <= '0;
            ram_vld <= 1'b0;
        end else begin
            ram_vld <= rd_en;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Output register with skid entry catching the in-flight RAM word on stall
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_vld  <= 1'b0;
            out_q    <= '0;
            skid_vld <= 1'b0;
            skid_q   <= '0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_vld  <= 1'b1;
                out_q    <= skid_q;
                skid_vld <= ram_vld;
                if (ram_vld) skid_q <= ram_data;
            end else if (ram_vld) begin
                out_vld <= 1'b1;
                out_q   <= ram_data;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (ram_vld) begin
            skid_vld <= 1'b1;
            skid_q   <= ram_data;
        end
    end

    assign m_axis.tvalid = out_vld;
    assign m_axis.tlast  = out_q[W_RXF_ENTRY-1];
    assign m_axis.tkeep  = out_q[W_DATA +: N_SYMBOLS];
    assign m_axis.tdata  = out_q[W_DATA-1:0];

endmodule

// File: tb/tb_mac_rx_pkt_fifo.sv
// tb/tb_mac_rx_pkt_fifo.sv - directed self-checking bench for mac_rx_pkt_fifo
module tb_mac_rx_pkt_fifo;
    import mac_params::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clk_en;
    logic [31:0] o_frames_ok;
    logic [31:0] o_frames_err;
    logic [31:0] o_frames_ovf;

    mac_rx_pkt_fifo_if s_if ();
    mac_rx_pkt_fifo_if m_if ();

    mac_rx_pkt_fifo #(
        .W_ADDR (4),
        .W_CNT  (32)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clk_en     (i_clk_en),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .o_frames_ok  (o_frames_ok),
        .o_frames_err (o_frames_err),
        .o_frames_ovf (o_frames_ovf)
    );

    always #5 i_clk = ~i_clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [36:0] rx_q[$];
    logic [36:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [37:0] prev_beat  = '0;
    logic        t4_run     = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Capture accepted output beats and check hold-while-stalled
    always @(negedge i_clk) begin
        if (i_reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata}, prev_beat);
            prev_stall <= m_if.tvalid & ~m_if.tready;
            prev_beat  <= {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata};
            if (m_if.tvalid && m_if.tready)
                rx_q.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u,
                        input logic en);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        i_clk_en    = en;
        @(posedge i_clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        i_clk_en    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        idle(2);
        i_reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int c = 0; c < budget && rx_q.size() < n; c++) @(negedge i_clk);
        repeat (6) @(negedge i_clk);
        #1;
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_nbeats"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tl;
        int          lat;
        logic [3:0]  k;
        logic [31:0] d;

        i_reset     = 1'b1;
        i_clk_en    = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b1;
        m_if.tready = 1'b1;
        @(posedge i_clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tlast", m_if.tlast, 0);
        chk("rst_tkeep", m_if.tkeep, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_ok", o_frames_ok, 0);
        chk("rst_err", o_frames_err, 0);
        chk("rst_ovf", o_frames_ovf, 0);

        // 20-beat frame exceeds 15 usable slots
        for (int i = 1; i <= 20; i++)
            send(32'hA000_0000 + i, (i == 20) ? 4'b0011 : 4'hF, i == 20, 1'b1, 1'b1);
        idle(10);
        chk("t1_ovf_nbeats", rx_q.size(), 0);
        chk("t1_ovf_cnt", o_frames_ovf, 1);
        chk("t1_ovf_ok", o_frames_ok, 0);
        rx_q.delete();

        // 10-beat good frame with latency check
        for (int i = 1; i <= 10; i++) begin
            k = (i == 10) ? 4'b0011 : 4'hF;
            d = 32'hB000_0000 + i;
            send(d, k, i == 10, 1'b1, 1'b1);
            exp_q.push_back({i == 10, k, d});
        end
        tl  = cyc;
        lat = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (m_if.tvalid) begin
                lat = cyc - tl;
                break;
            end
        end
        chk("t1_latency_le3", (lat >= 0) && (lat <= 3), 1);
        wait_out(10, 50);
        cmp_frames("t1_good");
        chk("t1_ok", o_frames_ok, 1);
        chk("t1_ovf_keep", o_frames_ovf, 1);

        // Mid-frame error then a good 3-beat frame
        do_reset();
        for (int i = 1; i <= 4; i++)
            send(32'hC000_0000 + i, 4'hF, 1'b0, i != 4, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            d = 32'hD000_0000 + i;
            send(d, 4'hF, i == 3, 1'b1, 1'b1);
            exp_q.push_back({i == 3, 4'hF, d});
        end
        wait_out(3, 50);
        cmp_frames("t2");
        chk("t2_err", o_frames_err, 1);
        chk("t2_ok", o_frames_ok, 1);
        chk("t2_ovf", o_frames_ovf, 0);

        // Clock-enable gaps; disabled cycles carry garbage tlast/tuser
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                d = 32'hE000_0000 + i;
                send(d, 4'hF, i == 14, 1'b1, 1'b1);
                exp_q.push_back({i == 14, 4'hF, d});
            end else begin
                send(32'hDEAD_0000 + i, 4'h1, 1'b1, 1'b0, 1'b0);
            end
        end
        wait_out(8, 60);
        cmp_frames("t3");
        chk("t3_ok", o_frames_ok, 1);
        chk("t3_err", o_frames_err, 0);

        // Backpressure and pointer wrap: 5 frames of 5 beats
        do_reset();
        t4_run = 1'b1;
        fork
            begin
                while (t4_run) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    @(posedge i_clk);
                    #1;
                end
                m_if.tready = 1'b1;
            end
        join_none
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < 5; b++) begin
                k = (b == 4) ? 4'b0111 : 4'hF;
                d = {8'h40 + 8'(f), 16'h0, 8'(b)};
                send(d, k, b == 4, 1'b1, 1'b1);
                exp_q.push_back({b == 4, k, d});
            end
            idle(20);
        end
        wait_out(25, 400);
        t4_run = 1'b0;
        idle(3);
        cmp_frames("t4");
        chk("t4_ok", o_frames_ok, 5);
        chk("t4_ovf", o_frames_ovf, 0);

        // Reset on beat 3 of a 7-beat frame, then a good 2-beat frame
        do_reset();
        send(32'hF000_0001, 4'hF, 1'b0, 1'b1, 1'b1);
        send(32'hF000_0002, 4'hF, 1'b0, 1'b1, 1'b1);
        i_reset = 1'b1;
        send(32'hF000_0003, 4'hF, 1'b0, 1'b1, 1'b1);
        i_reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            d = 32'h7700_0000 + i;
            send(d, 4'hF, i == 2, 1'b1, 1'b1);
            exp_q.push_back({i == 2, 4'hF, d});
        end
        wait_out(2, 50);
        cmp_frames("t5");
        chk("t5_ok", o_frames_ok, 1);
        chk("t5_err", o_frames_err, 0);
        chk("t5_ovf", o_frames_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
